// File: rtl/usr_seq_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencing controller.
package usr_ctrl_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TX_SHIFT,
    RX_SHIFT,
    RX_DONE
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Shift register mode driven while the controller sits in a given state.
  function automatic logic [1:0] state_mode(state_e st);
    case (st)
      LOAD:     return MODE_LOAD;
      TX_SHIFT: return MODE_SHL;
      RX_SHIFT: return MODE_SHR;
      default:  return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Transmit/receive requester handshake bundle of the sequencing controller.
interface usr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rx_req;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, rx_req,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_req,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencing controller: loads words into an external universal shift register
// and shifts them out MSB-first, or shifts a serial word in and strobes it out.
module usr_seq_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  usr_seq_ctrl_if.slave    bus,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] pin,
  output logic             sin,
  output logic             ser_out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pin_q, pin_d;
  logic             tx_ready;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
    end
  end

  // Next state and state-decoded outputs; transmit wins over receive in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pin_d    = pin_q;
    s        = state_mode(state_q);
    sin      = 1'b0;
    ser_out  = 1'b0;
    busy     = (state_q != IDLE);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;

    case (state_q)
      IDLE: begin
        tx_ready = ~rst;
        if (bus.tx_valid) begin
          pin_d   = bus.tx_data;
          state_d = LOAD;
        end else if (bus.rx_req) begin
          cnt_d   = '0;
          state_d = RX_SHIFT;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        ser_out = q[WIDTH-1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      RX_SHIFT: begin
        sin   = ser_in;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = RX_DONE;
      end
      RX_DONE: begin
        rx_valid = 1'b1;
        rx_data  = q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pin          = pin_q;
  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;

endmodule
